// File: rtl/bus_sel_rr_xbar_arb_if.sv
// bus_sel_rr_xbar_arb_if: fd request / fifo select bundle between fd ports and fifo arbiters
interface bus_sel_rr_xbar_arb_if #(
   parameter int PORT_NUM = 4
);
   logic [PORT_NUM*PORT_NUM-1:0] fd_req;
   logic [PORT_NUM-1:0]          fifo_ready;
   logic [PORT_NUM*PORT_NUM-1:0] fifo_bus_sel;
   logic [PORT_NUM*PORT_NUM-1:0] fd_grant;
   logic [PORT_NUM-1:0]          fifo_busy;
   modport master (output fd_req, fifo_ready, input fifo_bus_sel, fd_grant, fifo_busy);
   modport slave  (input fd_req, fifo_ready, output fifo_bus_sel, fd_grant, fifo_busy);
endinterface

// File: rtl/bus_sel_rr_xbar_arb.sv
// bus_sel_rr_xbar_arb: per-fifo round-robin arbiters with bounded hold, registered one-hot selects
module bus_sel_rr_xbar_arb #(
   parameter int PORT_NUM = 4,
   parameter int MAX_HOLD = 16,
   localparam int HOLD_W  = $clog2(MAX_HOLD) + 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   bus_sel_rr_xbar_arb_if.slave    bus
);
   localparam int PW = $clog2(PORT_NUM);
   typedef enum logic {IDLE, GRANT} state_t;
   state_t              r_state    [PORT_NUM];
   state_t              w_state_nx [PORT_NUM];
   logic [PW-1:0]       r_owner    [PORT_NUM];
   logic [PW-1:0]       w_owner_nx [PORT_NUM];
   logic [PW-1:0]       r_ptr      [PORT_NUM];
   logic [PW-1:0]       w_ptr_nx   [PORT_NUM];
   logic [PW-1:0]       w_win      [PORT_NUM];
   logic [HOLD_W-1:0]   r_cnt      [PORT_NUM];
   logic [HOLD_W-1:0]   w_cnt_nx   [PORT_NUM];
   logic [PORT_NUM-1:0] r_sel      [PORT_NUM];
   logic [PORT_NUM-1:0] w_sel_nx   [PORT_NUM];
   logic [PORT_NUM-1:0] w_col      [PORT_NUM];
   logic [PORT_NUM-1:0] w_others   [PORT_NUM];
   // descending scan so the lowest offset after ptr is the last (winning) assignment
   always_comb begin
      for (int y = 0; y < PORT_NUM; y++) begin
         for (int x = 0; x < PORT_NUM; x++) w_col[y][x] = bus.fd_req[x*PORT_NUM+y];
         w_others[y] = w_col[y] & ~(PORT_NUM'(1) << r_owner[y]);
         w_win[y]    = '0;
         for (int i = PORT_NUM; i >= 1; i--)
            if (w_col[y][(int'(r_ptr[y]) + i) % PORT_NUM]) w_win[y] = PW'((int'(r_ptr[y]) + i) % PORT_NUM);
      end
   end
   always_comb begin
      for (int y = 0; y < PORT_NUM; y++) begin
         w_state_nx[y] = r_state[y];
         w_owner_nx[y] = r_owner[y];
         w_ptr_nx[y]   = r_ptr[y];
         w_cnt_nx[y]   = r_cnt[y];
         if (r_state[y] == IDLE) begin
            if (|w_col[y] && bus.fifo_ready[y]) begin
               w_state_nx[y] = GRANT;
               w_owner_nx[y] = w_win[y];
               w_ptr_nx[y]   = w_win[y];
               w_cnt_nx[y]   = '0;
            end
         end else if (!w_col[y][r_owner[y]]) begin
            w_state_nx[y] = IDLE;
         end else if (bus.fifo_ready[y]) begin
            // saturated owner yields only when someone else is waiting
            if (r_cnt[y] == HOLD_W'(MAX_HOLD-1) && |w_others[y]) w_state_nx[y] = IDLE;
            else if (r_cnt[y] != HOLD_W'(MAX_HOLD-1)) w_cnt_nx[y] = r_cnt[y] + 1'b1;
         end
         w_sel_nx[y] = (w_state_nx[y] == GRANT) ? PORT_NUM'(1) << w_owner_nx[y] : '0;
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int y = 0; y < PORT_NUM; y++) begin
            r_state[y] <= IDLE;
            r_owner[y] <= '0;
            r_ptr[y]   <= PW'(PORT_NUM-1);
            r_cnt[y]   <= '0;
            r_sel[y]   <= '0;
         end
      end else begin
         r_state <= w_state_nx;
         r_owner <= w_owner_nx;
         r_ptr   <= w_ptr_nx;
         r_cnt   <= w_cnt_nx;
         r_sel   <= w_sel_nx;
      end
   end
   for (genvar y = 0; y < PORT_NUM; y++) begin : g_row
      assign bus.fifo_busy[y] = |r_sel[y];
      for (genvar x = 0; x < PORT_NUM; x++) begin : g_col
         assign bus.fifo_bus_sel[y*PORT_NUM+x] = r_sel[y][x];
         assign bus.fd_grant[x*PORT_NUM+y]     = r_sel[y][x];
      end
   end
endmodule

// File: tb/tb_bus_sel_rr_xbar_arb.sv
// tb_bus_sel_rr_xbar_arb: directed and random checks against a per-fifo owner/pointer model
module tb_bus_sel_rr_xbar_arb;
   localparam int P  = 4;
   localparam int MH = 4;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;
   bus_sel_rr_xbar_arb_if #(.PORT_NUM(P)) bus ();
   bus_sel_rr_xbar_arb #(.PORT_NUM(P), .MAX_HOLD(MH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   int n_cmp = 0;
   int n_err = 0;
   int m_own [P];
   int m_ptr [P];
   int m_cnt [P];
   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   task automatic model_reset();
      for (int y = 0; y < P; y++) begin
         m_own[y] = -1;
         m_ptr[y] = P - 1;
         m_cnt[y] = 0;
      end
   endtask
   // one clock of the arbitration rules, applied to each fifo's column of requests
   task automatic model_step();
      for (int y = 0; y < P; y++) begin
         logic [P-1:0] col;
         int w;
         for (int x = 0; x < P; x++) col[x] = bus.fd_req[x*P+y];
         if (m_own[y] < 0) begin
            if (col != 0 && bus.fifo_ready[y]) begin
               w = -1;
               for (int i = 1; i <= P && w < 0; i++) if (col[(m_ptr[y]+i)%P]) w = (m_ptr[y]+i)%P;
               m_own[y] = w;
               m_ptr[y] = w;
               m_cnt[y] = 0;
            end
         end else if (!col[m_own[y]]) begin
            m_own[y] = -1;
         end else if (bus.fifo_ready[y]) begin
            if (m_cnt[y] == MH-1 && (col & ~(P'(1) << m_own[y])) != 0) m_own[y] = -1;
            else if (m_cnt[y] < MH-1) m_cnt[y]++;
         end
      end
   endtask
   function automatic logic [15:0] e_sel();
      logic [15:0] v = '0;
      for (int y = 0; y < P; y++) if (m_own[y] >= 0) v[y*P+m_own[y]] = 1'b1;
      return v;
   endfunction
   function automatic logic [15:0] e_grant();
      logic [15:0] v = '0;
      for (int y = 0; y < P; y++) if (m_own[y] >= 0) v[m_own[y]*P+y] = 1'b1;
      return v;
   endfunction
   function automatic logic [15:0] e_busy();
      logic [15:0] v = '0;
      for (int y = 0; y < P; y++) v[y] = (m_own[y] >= 0);
      return v;
   endfunction
   task automatic check_all(input string tag);
      chk({tag, ".sel"}, bus.fifo_bus_sel, e_sel());
      chk({tag, ".grant"}, bus.fd_grant, e_grant());
      chk({tag, ".busy"}, 16'(bus.fifo_busy), e_busy());
   endtask
   task automatic step(input string tag, input logic [15:0] req, input logic [3:0] rdy);
      bus.fd_req     = req;
      bus.fifo_ready = rdy;
      @(posedge clk);
      model_step();
      #1;
      check_all(tag);
   endtask
   task automatic do_reset();
      #3 rst_n = 1'b0;
      model_reset();
      #1;
      chk("rst.sel", bus.fifo_bus_sel, 16'h0);
      chk("rst.grant", bus.fd_grant, 16'h0);
      chk("rst.busy", 16'(bus.fifo_busy), 16'h0);
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask
   logic [15:0] rq;
   logic [3:0]  rd;
   logic [3:0]  t3 [12] = '{4'h2, 4'h2, 4'h2, 4'h2, 4'h0, 4'h8, 4'h8, 4'h8, 4'h8, 4'h0, 4'h2, 4'h2};
   initial begin
      rst_n          = 1'b0;
      bus.fd_req     = '0;
      bus.fifo_ready = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("init.sel", bus.fifo_bus_sel, 16'h0);
      chk("init.busy", 16'(bus.fifo_busy), 16'h0);
      rst_n = 1'b1;
      // fd0 and fd2 contend for fifo1; fd0 has first priority out of reset
      step("t1", 16'h0202, 4'hF);
      chk("t1.row1", 16'(bus.fifo_bus_sel[7:4]), 16'h1);
      chk("t1.fd0f1", 16'(bus.fd_grant[1]), 16'h1);
      step("t1b", 16'h0202, 4'hF);
      step("t2a", 16'h0200, 4'hF);
      chk("t2.row1_clear", 16'(bus.fifo_bus_sel[7:4]), 16'h0);
      step("t2b", 16'h0200, 4'hF);
      chk("t2.row1_fd2", 16'(bus.fifo_bus_sel[7:4]), 16'h4);
      step("t2c", 16'h0000, 4'hF);
      // fd1 and fd3 hold requests to fifo0: bounded-hold alternation
      for (int i = 0; i < 12; i++) begin
         step("t3", 16'h1010, 4'hF);
         chk("t3.row0", 16'(bus.fifo_bus_sel[3:0]), 16'(t3[i]));
      end
      step("t4idle", 16'h0000, 4'hF);
      step("t4g", 16'h1010, 4'hF);
      chk("t4.row0_fd3", 16'(bus.fifo_bus_sel[3:0]), 16'h8);
      for (int i = 0; i < 5; i++) begin
         step("t4nr", 16'h1010, 4'hE);
         chk("t4.frozen", 16'(bus.fifo_bus_sel[3:0]), 16'h8);
      end
      for (int i = 0; i < 6; i++) step("t4r", 16'h1010, 4'hF);
      step("t5idle", 16'h0000, 4'hF);
      step("t5", 16'h0F00, 4'hF);
      chk("t5.sel", bus.fifo_bus_sel, 16'h4444);
      chk("t5.grant", bus.fd_grant, 16'h0F00);
      chk("t5.busy", 16'(bus.fifo_busy), 16'hF);
      do_reset();
      step("t6", 16'h4004, 4'hF);
      chk("t6.row2_fd0", 16'(bus.fifo_bus_sel[11:8]), 16'h1);
      rq = '0;
      for (int n = 0; n < 400; n++) begin
         for (int b = 0; b < 16; b++) if ($urandom_range(7) == 0) rq[b] = ~rq[b];
         for (int b = 0; b < 4; b++) rd[b] = ($urandom_range(3) != 0);
         if ($urandom_range(99) == 0) do_reset();
         step("rnd", rq, rd);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
